// File: rtl/alu_sequencer_if.sv
// Bus bundle between the sequencer and its instruction memory, register file and ALU.
// The master modport is the sequencer side; slave is the environment side.
interface alu_sequencer_if #(
    parameter int PC_W = 8
);
    logic            imem_req;
    logic [PC_W-1:0] imem_addr;
    logic            imem_valid;
    logic [15:0]     imem_instr;
    logic [3:0]      rf_raddr1;
    logic [3:0]      rf_raddr2;
    logic            rf_we;
    logic [3:0]      rf_waddr;
    logic [15:0]     rf_wdata;
    logic [3:0]      alu_code;
    logic [15:0]     accum;
    logic            branch_check;

    modport master (
        output imem_req, imem_addr, rf_raddr1, rf_raddr2, rf_we, rf_waddr, rf_wdata, alu_code,
        input  imem_valid, imem_instr, accum, branch_check
    );

    modport slave (
        input  imem_req, imem_addr, rf_raddr1, rf_raddr2, rf_we, rf_waddr, rf_wdata, alu_code,
        output imem_valid, imem_instr, accum, branch_check
    );
endinterface

// File: rtl/alu_sequencer.sv
// Multi-cycle control FSM for the 16-bit CPU: fetch, decode, execute, write-back/branch.
// Owns the PC and the retired-instruction counter; stops for good on a HALT opcode.
module alu_sequencer #(
    parameter int              PC_W     = 8,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  run,
    alu_sequencer_if.master       bus,
    output logic [PC_W-1:0]       pc,
    output logic                  halted,
    output logic [15:0]           instr_count
);
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_DECODE = 3'd2;
    localparam logic [2:0] S_EXEC   = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;
    localparam logic [2:0] S_BRANCH = 3'd5;
    localparam logic [2:0] S_HALT   = 3'd6;

    logic [2:0]      r_state;
    logic [2:0]      w_state_next;
    logic [PC_W-1:0] r_pc;
    logic [15:0]     r_ir;
    logic [15:0]     r_result;
    logic            r_taken;
    logic            r_halted;
    logic [15:0]     r_instr_count;

    logic [3:0]      w_opcode;
    logic            w_is_branch;
    logic            w_is_halt;
    logic            w_rd_phase;
    logic [PC_W-1:0] w_offset;

    assign w_opcode    = r_ir[15:12];
    assign w_is_branch = (r_ir[15:14] == 2'b11);
    assign w_is_halt   = (w_opcode == 4'b0000);
    assign w_rd_phase  = (r_state == S_DECODE) || (r_state == S_EXEC);
    assign w_offset    = {{(PC_W-4){r_ir[3]}}, r_ir[3:0]};

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:   if (run) w_state_next = S_FETCH;
            S_FETCH:  if (bus.imem_valid) w_state_next = S_DECODE;
            S_DECODE: w_state_next = S_EXEC;
            S_EXEC: begin
                if (w_is_halt)        w_state_next = S_HALT;
                else if (w_is_branch) w_state_next = S_BRANCH;
                else                  w_state_next = S_WB;
            end
            S_WB, S_BRANCH: w_state_next = run ? S_FETCH : S_IDLE;
            S_HALT:   w_state_next = S_HALT;
            default:  w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_pc          <= RESET_PC;
            r_ir          <= '0;
            r_result      <= '0;
            r_taken       <= 1'b0;
            r_halted      <= 1'b0;
            r_instr_count <= '0;
        end else begin
            r_state <= w_state_next;
            if (r_state == S_FETCH && bus.imem_valid)
                r_ir <= bus.imem_instr;
            if (r_state == S_EXEC) begin
                r_result <= bus.accum;
                r_taken  <= bus.branch_check;
                if (w_is_halt)
                    r_halted <= 1'b1;
            end
            if (r_state == S_WB) begin
                r_pc          <= r_pc + PC_W'(1);
                r_instr_count <= r_instr_count + 16'd1;
            end
            // Branch target wraps modulo 2^PC_W in either direction.
            if (r_state == S_BRANCH) begin
                r_pc          <= r_taken ? (r_pc + w_offset) : (r_pc + PC_W'(1));
                r_instr_count <= r_instr_count + 16'd1;
            end
        end
    end

    // Branches read rs1/rs2 from [11:8]/[7:4]; ALU ops keep rd in [11:8].
    always_comb begin
        bus.rf_raddr1 = 4'd0;
        bus.rf_raddr2 = 4'd0;
        if (w_rd_phase) begin
            bus.rf_raddr1 = w_is_branch ? r_ir[11:8] : r_ir[7:4];
            bus.rf_raddr2 = w_is_branch ? r_ir[7:4]  : r_ir[3:0];
        end
    end

    assign bus.imem_req  = (r_state == S_FETCH);
    assign bus.imem_addr = r_pc;
    assign bus.alu_code  = (r_state == S_EXEC) ? w_opcode : 4'd0;
    assign bus.rf_we     = (r_state == S_WB);
    assign bus.rf_waddr  = (r_state == S_WB) ? r_ir[11:8] : 4'd0;
    assign bus.rf_wdata  = (r_state == S_WB) ? r_result : 16'd0;

    assign pc          = r_pc;
    assign halted      = r_halted;
    assign instr_count = r_instr_count;
endmodule
